egress_arbiter: RTL

//  Per-output-port arbiter that sits downstream of the four switch_port ingress FIFOs.

---
 rtl/switch_pkg.sv | 7 +
 rtl/rr_picker.sv | 24 ++
 rtl/egress_arbiter.sv | 84 ++++++++
 3 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: types and defaults shared by the switch ingress, parser and egress arbiters
package switch_pkg;
    localparam int NUM_PORTS_DEF = 4;
    typedef logic [$clog2(NUM_PORTS_DEF)-1:0] port_idx_t;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    typedef enum logic [1:0] {ERR, SDP, MDP, BDP} p_type;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: rotated priority encoder; first set req bit after last wins, wrapping mod N
module rr_picker import switch_pkg::*; #(
    parameter int N = NUM_PORTS_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         any
);
    always_comb begin
        logic [W-1:0] idx;
        winner = '0;
        any = 1'b0;
        idx = last;
        for (int i = 0; i < N; i++) begin
            idx = (idx == W'(N - 1)) ? '0 : idx + W'(1);
            if (!any && req[idx]) begin
                winner = idx;
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/egress_arbiter.sv
// egress_arbiter: round-robin selection of one ingress head per output, with
// valid/ready handshake, single-cycle pop to the winner and timeout drop
module egress_arbiter import switch_pkg::*; #(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_ID = 0,
    parameter int TIMEOUT = 16,
    localparam int W = $clog2(NUM_PORTS),
    localparam int CW = $clog2(TIMEOUT) + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS-1:0]           head_valid,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] head_target,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [W-1:0]                   mux_select,
    output logic [NUM_PORTS-1:0]           pop,
    output logic                           drop,
    output logic                           busy
);
    arb_state_t state_q, state_d;
    logic [NUM_PORTS-1:0] req;
    logic [W-1:0] winner_q, winner_d, last_q, last_d, pick;
    logic [CW-1:0] wait_q, wait_d;
    logic any, in_grant, timeout, fire;
    logic unused_tgt;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_req
        assign req[g] = head_valid[g] & head_target[g*NUM_PORTS+PORT_ID];
    end
    // only this output's bit of each mask matters here
    assign unused_tgt = ^head_target;

    rr_picker #(.N(NUM_PORTS)) u_pick (
        .req    (req),
        .last   (last_q),
        .winner (pick),
        .any    (any)
    );

    assign in_grant = state_q == ARB_GRANT;
    assign timeout = !out_ready && wait_q == CW'(TIMEOUT - 1);
    assign fire = in_grant && (out_ready || timeout);
    assign pop = fire ? {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner_q : '0;
    assign drop = in_grant && timeout;
    assign out_valid = in_grant;
    assign busy = in_grant;
    assign mux_select = winner_q;

    always_comb begin
        state_d = state_q;
        winner_d = winner_q;
        last_d = last_q;
        wait_d = wait_q;
        if (!in_grant) begin
            wait_d = '0;
            if (any) begin
                state_d = ARB_GRANT;
                winner_d = pick;
            end
        end else if (fire) begin
            state_d = ARB_IDLE;
            last_d = winner_q;
        end else if (!req[winner_q]) begin
            state_d = ARB_IDLE;
        end else begin
            wait_d = (&wait_q) ? wait_q : wait_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            winner_q <= '0;
            last_q <= W'(NUM_PORTS - 1);
            wait_q <= '0;
        end else begin
            state_q <= state_d;
            winner_q <= winner_d;
            last_q <= last_d;
            wait_q <= wait_d;
        end
    end
endmodule
